uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one 19200-baud UART transmitter among N_REQ byte producers.
- Sits between producer logic (timers, status reporters, debug taps) and the uart instance in the top level.
- Owns the UART's tx_data/tx_w_n write interface and watches tx_busy_n to pace one byte at a time.
- Producers see a simple active-low request/acknowledge handshake.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- BUSY_WAIT, 16, max clk_48 cycles to wait for tx_busy_n to go low after a write strobe before declaring timeout.
- ID_W, $clog2(N_REQ), width of grant index (derived, not overridden).

Ports:
- clk_48  in  1  48 MHz system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- req_n  in  N_REQ  per-requester byte request, active-low level; held until ack_n pulse.
- req_data  in  8*N_REQ  per-requester byte; requester i at [8*i+7:8*i]; stable while req_n[i] low.
- ack_n  out  N_REQ  one-cycle active-low pulse: byte of requester i latched for transmit.
- tx_data  out  8  byte to UART.
- tx_w_n  out  1  UART write strobe, active-low, exactly one cycle per byte.
- tx_busy_n  in  1  UART busy, active-low (low while shifting a frame).
- grant_id  out  ID_W  index of requester currently/last served.
- active  out  1  high from grant until UART frame completes.
- timeout_err  out  1  sticky; set on BUSY_WAIT expiry, cleared only by reset.

Behaviour:
- Reset: rst_n sampled low at a clk_48 edge resets, regardless of state. Resets FSM to IDLE.
  - Outputs: ack_n all 1, tx_w_n 1, tx_data 8'h00, grant_id 0, active 0, timeout_err 0.
  - Internal: round-robin pointer 0, wait counter 0.
  - Mid-frame reset abandons the byte. The UART finishes its frame on its own; after reset, IDLE still waits for tx_busy_n high before granting.
- All outputs are registered.
- States: IDLE, STROBE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Grant only when some req_n bit is low and tx_busy_n is high.
  - Pick the first low req_n bit at or after pointer, searching upward with wrap.
  - Same edge: latch tx_data from the winner, set grant_id, set active=1, pulse that ack_n low, go to STROBE.
- STROBE:
  - tx_w_n=0 for this one cycle; ack_n back to all 1.
  - Pointer <= grant_id+1, wrapping to 0 after N_REQ-1.
  - Wait counter cleared; next state WAIT_BUSY.
- WAIT_BUSY:
  - tx_w_n=1. If tx_busy_n low, go to WAIT_DONE.
  - Else increment counter. When counter reaches BUSY_WAIT-1 with tx_busy_n still high: set timeout_err, active=0, go to IDLE (byte considered lost).
- WAIT_DONE:
  - Stay while tx_busy_n low. On tx_busy_n high: active=0, go to IDLE.
- Latency: req_n low in IDLE → ack_n low at next edge (1 cycle) → tx_w_n low the following cycle (2 cycles from request sample).
- Minimum spacing between tx_w_n strobes is one UART frame plus 2 cycles. Back-to-back grants take no idle cycle beyond the IDLE evaluation cycle.
- Fairness:
  - A requester holding req_n low continuously is served at most once per N_REQ grants while others also request.
  - A single lone requester is served every frame.
- Simultaneous events:
  - A req_n deasserted before grant is ignored (no ack).
  - A req_n that changes while not in IDLE has no effect until IDLE.
  - A requester must deassert req_n on the cycle after its ack_n. If it is still low in the next IDLE, that is a new request.
- Width rules: wait counter is $clog2(BUSY_WAIT)+1 bits and saturates, never wraps. Pointer wraps modulo N_REQ (not a power-of-2 mask).

Decomposition:
- Package uart_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, STROBE, WAIT_BUSY, WAIT_DONE}.
  - localparam BYTE_W=8.
  - Shared with uart for future RX arbitration.
- Sub-module rr_pick (combinational round-robin priority select).
  - Inputs: request vector (active-high), pointer.
  - Outputs: valid, index.
  - Reusable for later resource sharing.

Test Plan:
- Reset then single request: hold req_n=4'b1110 with req_data[7:0]=8'h54.
  - ack_n[0] low exactly 1 cycle, next cycle tx_w_n low 1 cycle with tx_data=8'h54.
  - Then active=1 until the UART model raises tx_busy_n.
- All four requesting with bytes 8'h41,8'h42,8'h43,8'h44 held continuously: transmitted order 41,42,43,44,41..., grant_id 0,1,2,3,0.
- Pointer wrap: after serving req 3, requests 1 and 2 both low → grant 1, then 2.
- Busy timeout: UART model never pulls tx_busy_n low after strobe.
  - timeout_err=1 exactly BUSY_WAIT cycles after WAIT_BUSY entry; FSM back in IDLE; next request still served.
  - timeout_err stays 1 until rst_n.
- Reset mid-frame: pull rst_n low for 1 cycle while in WAIT_DONE with tx_busy_n low.
  - Outputs go to reset values; no grant until tx_busy_n high.
  - Pending request then acked with grant_id from pointer 0.
- Start while UART busy: tx_busy_n low out of reset, req_n[2] low → no ack_n until tx_busy_n high, then ack_n[2] the next edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the TX arbiter state encoding.
// Kept separate so a future RX-side arbiter can reuse the same types.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin priority select: returns the first asserted
// request at or after ptr, searching upward and wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int j;
    j     = 0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte
// producers. Producers use an active-low req/ack handshake; the arbiter
// owns the UART write strobe and paces one byte per UART frame by watching
// tx_busy_n. All outputs are registered.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int BUSY_WAIT = 16,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                    clk_48,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_n,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        ack_n,
  output logic [BYTE_W-1:0]       tx_data,
  output logic                    tx_w_n,
  input  logic                    tx_busy_n,
  output logic [ID_W-1:0]         grant_id,
  output logic                    active,
  output logic                    timeout_err
);

  // Wait counter carries one spare bit so it can saturate instead of wrap.
  localparam int                CNT_W    = $clog2(BUSY_WAIT) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BUSY_WAIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(N_REQ - 1);

  arb_state_t              state, state_d;
  logic [ID_W-1:0]         ptr, ptr_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [N_REQ-1:0]        ack_n_d;
  logic [BYTE_W-1:0]       tx_data_d;
  logic                    tx_w_n_d;
  logic [ID_W-1:0]         grant_id_d;
  logic                    active_d;
  logic                    timeout_d;

  logic [N_REQ-1:0]        req_vec;
  logic                    pick_valid;
  logic [ID_W-1:0]         pick_idx;

  // Pointer advance wraps modulo N_REQ, which need not be a power of two.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    return (id == ID_LAST) ? '0 : id + 1'b1;
  endfunction

  // Saturating increment for the busy-wait counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  assign req_vec = ~req_n;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req   (req_vec),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    cnt_d      = cnt;
    ack_n_d    = '1;
    tx_w_n_d   = 1'b1;
    tx_data_d  = tx_data;
    grant_id_d = grant_id;
    active_d   = active;
    timeout_d  = timeout_err;

    unique case (state)
      IDLE: begin
        // A UART still finishing a frame (e.g. after a reset) blocks grants.
        if (pick_valid && tx_busy_n) begin
          tx_data_d         = req_data[int'(pick_idx)*BYTE_W +: BYTE_W];
          grant_id_d        = pick_idx;
          active_d          = 1'b1;
          ack_n_d[pick_idx] = 1'b0;
          state_d           = STROBE;
        end
      end

      STROBE: begin
        tx_w_n_d = 1'b0;
        ptr_d    = next_ptr(grant_id);
        cnt_d    = '0;
        state_d  = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        if (!tx_busy_n) begin
          state_d = WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          // UART never acknowledged the strobe: drop the byte, flag it.
          timeout_d = 1'b1;
          active_d  = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = sat_inc(cnt);
        end
      end

      WAIT_DONE: begin
        if (tx_busy_n) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_48) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Output, pointer and counter registers.
  always_ff @(posedge clk_48) begin
    if (!rst_n) begin
      ptr         <= '0;
      cnt         <= '0;
      ack_n       <= '1;
      tx_w_n      <= 1'b1;
      tx_data     <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ptr         <= ptr_d;
      cnt         <= cnt_d;
      ack_n       <= ack_n_d;
      tx_w_n      <= tx_w_n_d;
      tx_data     <= tx_data_d;
      grant_id    <= grant_id_d;
      active      <= active_d;
      timeout_err <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb: directed scenarios plus a randomized phase,
// all checked cycle-by-cycle against a transaction-level reference model.
module tb_uart_tx_arb;

  localparam int N   = 4;
  localparam int BW  = 16;
  localparam int IDW = 2;

  logic             clk_48 = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_n;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     ack_n;
  logic [7:0]       tx_data;
  logic             tx_w_n;
  logic             tx_busy_n;
  logic [IDW-1:0]   grant_id;
  logic             active;
  logic             timeout_err;

  always #5 clk_48 = ~clk_48;

  uart_tx_arb #(
    .N_REQ     (N),
    .BUSY_WAIT (BW)
  ) dut (
    .clk_48      (clk_48),
    .rst_n       (rst_n),
    .req_n       (req_n),
    .req_data    (req_data),
    .ack_n       (ack_n),
    .tx_data     (tx_data),
    .tx_w_n      (tx_w_n),
    .tx_busy_n   (tx_busy_n),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // producers
  bit         pend   [N];
  bit         rearm  [N];
  bit         hold   [N];
  logic [7:0] bytes  [N];
  bit         rand_mode = 0;

  // UART model
  bit uart_ignore = 0;
  bit force_busy  = 0;
  bit strobe_seen = 0;
  int busy_left   = 0;
  int frame_len   = 8;

  // reference model
  int         m_ptr = 0;
  int         m_gid = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_free = 1, m_in_txn = 0, m_waiting = 0, m_timeout = 0;
  int         free_at = 0, strobe_due = -1, timeout_at = 32'h7fffffff;
  int         last_strobe_cyc = 0;

  logic [7:0] tx_log[$];
  int         gid_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_winner(input int ptr, input logic [N-1:0] act);
    for (int k = 0; k < N; k++) begin
      if (act[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_n[i]          = ~pend[i];
      req_data[8*i +: 8] = bytes[i];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_gid = 0; m_data = 8'h00;
    m_free = 1; m_in_txn = 0; m_waiting = 0; m_timeout = 0;
    strobe_due = -1; timeout_at = 32'h7fffffff;
  endtask

  // One clock: sample, predict, compare, then update UART model and producers.
  task automatic step();
    logic [N-1:0] s_req;
    logic         s_busy, s_rst;
    bit           exp_grant;
    bit           exp_active;
    int           idx;
    logic [N-1:0] exp_ack;
    @(posedge clk_48);
    #1;
    cyc++;
    s_req = req_n; s_busy = tx_busy_n; s_rst = rst_n;
    exp_grant = 0; idx = 0;
    if (!s_rst) begin
      model_reset();
    end else begin
      if (m_waiting && cyc >= free_at) begin
        m_free = 1; m_in_txn = 0; m_waiting = 0;
      end
      exp_grant = m_free && s_busy && (s_req != '1);
      if (exp_grant) begin
        idx        = rr_winner(m_ptr, ~s_req);
        m_ptr      = (idx + 1) % N;
        m_gid      = idx;
        m_data     = bytes[idx];
        m_free     = 0;
        m_in_txn   = 1;
        strobe_due = cyc + 1;
      end
    end
    if (cyc >= timeout_at) m_timeout = 1;
    exp_ack = '1;
    if (exp_grant) exp_ack[idx] = 1'b0;
    exp_active = m_in_txn && !(m_waiting && cyc >= free_at - 1);

    check("ack_n", ack_n, exp_ack);
    check("tx_w_n", tx_w_n, (cyc == strobe_due) ? 1'b0 : 1'b1);
    check("tx_data", tx_data, m_data);
    check("grant_id", grant_id, m_gid);
    check("active", active, exp_active);
    check("timeout_err", timeout_err, m_timeout);

    if (cyc == strobe_due) begin
      tx_log.push_back(tx_data);
      gid_log.push_back(int'(grant_id));
      last_strobe_cyc = cyc;
      if (uart_ignore) begin
        m_waiting  = 1;
        free_at    = cyc + BW + 1;
        timeout_at = cyc + BW;
      end
    end

    // UART: a strobe seen during the last cycle starts a frame at this edge.
    if (!uart_ignore && strobe_seen) begin
      if (rand_mode) frame_len = $urandom_range(1, 12);
      busy_left = frame_len;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0 && m_in_txn && !m_waiting) begin
        m_waiting = 1;
        free_at   = cyc + 2;
      end
    end
    tx_busy_n   = !(force_busy || busy_left > 0);
    strobe_seen = (tx_w_n == 1'b0);

    // producers: drop request after ack; optionally re-request or randomize
    for (int i = 0; i < N; i++) begin
      if (ack_n[i] === 1'b0) begin
        pend[i]  = 0;
        rearm[i] = hold[i];
      end else if (rearm[i]) begin
        rearm[i] = 0;
        pend[i]  = 1;
      end else if (rand_mode) begin
        if (!pend[i] && $urandom_range(0, 7) == 0) begin
          pend[i]  = 1;
          bytes[i] = 8'($urandom);
        end else if (pend[i] && $urandom_range(0, 31) == 0) begin
          pend[i] = 0;
        end
      end
    end
    apply();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_quiet(input int max);
    for (int k = 0; k < max && (m_in_txn || busy_left > 0); k++) step();
    check("quiet_bound", (m_in_txn || busy_left > 0), 1'b0);
  endtask

  task automatic run_until_log(input int n, input int max, input string tag);
    for (int k = 0; k < max && tx_log.size() < n; k++) step();
    check(tag, tx_log.size(), n);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; rearm[i] = 0; hold[i] = 0;
    end
    apply();
  endtask

  initial begin
    int n0;
    rst_n     = 1'b0;
    tx_busy_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; rearm[i] = 0; hold[i] = 0; bytes[i] = 8'h00;
    end
    apply();

    // reset values
    step();
    step();
    check("rst_ack_n", ack_n, 4'hF);
    check("rst_tx_w_n", tx_w_n, 1'b1);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_grant_id", grant_id, 0);
    check("rst_active", active, 1'b0);
    check("rst_timeout", timeout_err, 1'b0);
    rst_n = 1'b1;
    step();

    // single request
    pend[0] = 1; bytes[0] = 8'h54; apply();
    step();
    check("t1_ack", ack_n, 4'b1110);
    step();
    check("t1_strobe", tx_w_n, 1'b0);
    check("t1_data", tx_data, 8'h54);
    check("t1_ack_rel", ack_n, 4'hF);
    step(); step(); step();
    check("t1_busy", tx_busy_n, 1'b0);
    check("t1_active", active, 1'b1);
    wait_quiet(40);
    step();
    check("t1_idle", active, 1'b0);

    // all four requesting continuously
    do_reset();
    tx_log.delete(); gid_log.delete();
    for (int i = 0; i < N; i++) begin
      bytes[i] = 8'h41 + 8'(i); pend[i] = 1; hold[i] = 1;
    end
    apply();
    run_until_log(8, 400, "t2_count");
    clear_reqs();
    check("t2_b0", tx_log[0], 8'h41);
    check("t2_b1", tx_log[1], 8'h42);
    check("t2_b2", tx_log[2], 8'h43);
    check("t2_b3", tx_log[3], 8'h44);
    check("t2_b4", tx_log[4], 8'h41);
    check("t2_g3", gid_log[3], 3);
    check("t2_g4", gid_log[4], 0);
    check("t2_g7", gid_log[7], 3);

    // pointer wrap after serving requester 3
    tx_log.delete(); gid_log.delete();
    pend[1] = 1; bytes[1] = 8'h61;
    pend[2] = 1; bytes[2] = 8'h62;
    apply();
    run_until_log(2, 200, "t3_count");
    check("t3_g0", gid_log[0], 1);
    check("t3_g1", gid_log[1], 2);
    wait_quiet(40);

    // busy timeout
    tx_log.delete(); gid_log.delete();
    uart_ignore = 1;
    pend[0] = 1; bytes[0] = 8'h70; apply();
    run_until_log(1, 20, "t4_strobe");
    for (int k = 0; k < 60 && timeout_err !== 1'b1; k++) step();
    check("t4_latency", cyc - last_strobe_cyc, BW);
    check("t4_active", active, 1'b0);
    uart_ignore = 0;
    pend[2] = 1; bytes[2] = 8'h72; apply();
    run_until_log(2, 20, "t4_next");
    check("t4_next_data", tx_log[1], 8'h72);
    wait_quiet(40);
    step();
    check("t4_sticky", timeout_err, 1'b1);

    // reset mid-frame
    tx_log.delete(); gid_log.delete();
    frame_len = 30;
    pend[2] = 1; bytes[2] = 8'h32; apply();
    run_until_log(1, 20, "t5_first");
    check("t5_first_gid", gid_log[0], 2);
    pend[1] = 1; bytes[1] = 8'h31;
    pend[3] = 1; bytes[3] = 8'h33;
    apply();
    for (int k = 0; k < 10 && tx_busy_n !== 1'b0; k++) step();
    step(); step(); step();
    do_reset();
    check("t5_rst_ack", ack_n, 4'hF);
    check("t5_rst_data", tx_data, 8'h00);
    check("t5_rst_active", active, 1'b0);
    check("t5_rst_timeout", timeout_err, 1'b0);
    check("t5_uart_busy", tx_busy_n, 1'b0);
    run_until_log(2, 100, "t5_after");
    check("t5_after_gid", gid_log[1], 1);
    check("t5_after_data", tx_log[1], 8'h31);
    pend[3] = 0; apply();
    wait_quiet(60);
    frame_len = 8;

    // start while UART busy
    clear_reqs();
    wait_quiet(60);
    force_busy = 1;
    do_reset();
    n0 = tx_log.size();
    pend[2] = 1; bytes[2] = 8'h5A; apply();
    repeat (10) step();
    check("t6_no_grant", tx_log.size(), n0);
    check("t6_ack_held", ack_n, 4'hF);
    force_busy = 0;
    step();
    check("t6_ack_wait", ack_n, 4'hF);
    step();
    check("t6_ack", ack_n, 4'b1011);
    check("t6_gid", grant_id, 2);
    wait_quiet(60);

    // randomized traffic
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    clear_reqs();
    wait_quiet(60);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
